// File: rtl/alu_pkg.sv
// Shared arithmetic-unit definitions.
// Divider width, FSM states and helpers.
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Magnitude; the most negative value maps to its unsigned image.
  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v,
    input logic             s
  );
    return (s & v[WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration.
// Shifts {P,Q}, trial-subtracts D, restores on borrow.
module div_step
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W-1:0] p_nxt,
  output logic [W-1:0] q_nxt
);

  logic [W:0]   sh;
  logic [W+1:0] t;
  logic         ok;
  logic         unused_t;

  assign sh       = {p, q[W-1]};
  assign t        = {1'b0, sh} - {2'b00, d};
  assign ok       = ~t[W+1];
  assign unused_t = t[W];

  // P < D before the step, so either result fits W bits.
  assign p_nxt = ok ? t[W-1:0] : sh[W-1:0];
  assign q_nxt = {q[W-2:0], ok};

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, signed or unsigned.
// One quotient bit per cycle, then a sign fix-up cycle.
module divider
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             ovf_pend;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             accept;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  assign accept = start & ((state == IDLE) | (state == DONE));

  div_step #(.W(WIDTH)) u_step (
    .p     (p),
    .q     (q),
    .d     (d),
    .p_nxt (p_nxt),
    .q_nxt (q_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            dvd_neg  <= is_signed & dividend[WIDTH-1];
            dvs_neg  <= is_signed & divisor[WIDTH-1];
            ovf_pend <= is_signed & (dividend == MIN_NEG)
                        & (divisor == '1);
            overflow <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              done        <= 1'b0;
              busy        <= 1'b1;
              cnt         <= '0;
              p           <= '0;
              q           <= mag(dividend, is_signed);
              d           <= mag(divisor, is_signed);
              state       <= RUN;
            end
          end
        end
        RUN: begin
          p   <= p_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= (dvd_neg ^ dvs_neg) ? -q : q;
          remainder <= dvd_neg ? -p : p;
          overflow  <= ovf_pend;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Randomized and directed checks of divider.
// Results compared with an integer-arithmetic model.
module tb_divider;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       is_signed = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       overflow;

  int n_chk = 0;
  int n_pass = 0;

  divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic model(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       s,
    output logic [7:0] eq,
    output logic [7:0] er,
    output logic       edz,
    output logic       eov
  );
    int sa;
    int sb;
    edz = 1'b0;
    eov = 1'b0;
    sa  = $signed(a);
    sb  = $signed(b);
    if (b == 0) begin
      eq  = 8'hFF;
      er  = a;
      edz = 1'b1;
    end else if (!s) begin
      eq = a / b;
      er = a % b;
    end else if (sa == -128 && sb == -1) begin
      eq  = 8'h80;
      er  = 8'h00;
      eov = 1'b1;
    end else begin
      eq = 8'(sa / sb);
      er = 8'(sa % sb);
    end
  endtask

  task automatic pulse(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       s
  );
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done after an accept edge; returns edges and busy count.
  task automatic wait_done(output int edges, output int nbusy);
    edges = 0;
    nbusy = busy ? 1 : 0;
    while (!done && edges < 30) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) nbusy++;
    end
  endtask

  task automatic do_op(
    input string      tag,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       s,
    input logic       timing
  );
    logic [7:0] eq, er;
    logic       edz, eov;
    int         edges, nbusy;
    model(a, b, s, eq, er, edz, eov);
    pulse(a, b, s);
    if (timing && b != 0) chk({tag, ".done_low"}, done, 1'b0);
    wait_done(edges, nbusy);
    if (timing) begin
      chk({tag, ".lat"}, edges, (b == 0) ? 0 : 9);
      chk({tag, ".busy_cyc"}, nbusy, (b == 0) ? 0 : 9);
    end
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dz"}, div_by_zero, edz);
    chk({tag, ".ov"}, overflow, eov);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  initial begin
    int edges, nbusy;
    logic [7:0] a, b;
    logic       s;

    #12;
    chk("rst.q", quotient, 0);
    chk("rst.r", remainder, 0);
    chk("rst.flags", {busy, done, div_by_zero, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op("u200_7", 8'd200, 8'd7, 1'b0, 1'b1);
    do_op("s-100_7", 8'h9C, 8'h07, 1'b1, 1'b1);
    do_op("u55_0", 8'h37, 8'h00, 1'b0, 1'b1);
    do_op("s55_0", 8'h37, 8'h00, 1'b1, 1'b1);
    do_op("s-128_-1", 8'h80, 8'hFF, 1'b1, 1'b1);
    do_op("u128_255", 8'h80, 8'hFF, 1'b0, 1'b1);
    do_op("s7_-2", 8'h07, 8'hFE, 1'b1, 1'b1);

    // A start while busy must not disturb the running operation.
    pulse(8'd100, 8'd3, 1'b0);
    repeat (3) @(posedge clk);
    pulse(8'd9, 8'd9, 1'b0);
    chk("ign.busy", busy, 1'b1);
    wait_done(edges, nbusy);
    chk("ign.q", quotient, 33);
    chk("ign.r", remainder, 1);
    chk("ign.done", done, 1'b1);
    do_op("b2b9_9", 8'd9, 8'd9, 1'b0, 1'b1);

    // Reset in mid-flight.
    pulse(8'd200, 8'd7, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst.q", quotient, 0);
    chk("mrst.r", remainder, 0);
    chk("mrst.bd", {busy, done}, 0);
    chk("mrst.state", dut.state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 8'd200, 8'd7, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      s = 1'($urandom);
      if (i % 10 == 0) begin
        a = 8'h80;
        b = 8'hFF;
      end
      do_op($sformatf("rnd%0d", i), a, b, s, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
